// File: rtl/c17_pipe_pkg.sv
// Shared types, constants and helper functions for the pipelined c17 array.
package c17_pipe_pkg;

    // Upper bound on channel count; popcount is sized for this and callers zero-extend.
    localparam int unsigned MAX_CH     = 64;
    localparam int unsigned PC_W       = $clog2(MAX_CH + 1);
    localparam int unsigned MIN_STAGES = 1;
    localparam int unsigned MAX_STAGES = 2;

    // Only 1 (outputs registered) or 2 (internal nodes also registered) are meaningful.
    function automatic bit stages_legal(input int unsigned s);
        return (s >= MIN_STAGES) && (s <= MAX_STAGES);
    endfunction

    // Single-bit c17 evaluation, returns {n22, n23}.
    function automatic logic [1:0] c17_eval(input logic n1, input logic n2, input logic n3,
                                            input logic n6, input logic n7);
        logic n10;
        n10 = ~(n6 & n3);
        return {(n1 & n3) | (n2 & n10), n10 & (n2 | n7)};
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [MAX_CH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/c17_pipe_stage.sv
// One valid/ready register slice; data is captured only on an accepted transfer.
module c17_pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q;
    logic             load;

    // Accept when empty or when the current contents leave this cycle.
    always_comb begin
        up_ready = ~valid_q | dn_ready;
        load     = up_valid & up_ready;
        valid_d  = load | (valid_q & ~dn_ready);
    end

    // Valid bit and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                data_q <= up_data;
            end
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;

endmodule

// File: rtl/c17_pipe_array.sv
// Multi-channel pipelined c17 core with valid/ready flow control and an output toggle counter.
module c17_pipe_array
    import c17_pipe_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CHANNELS-1:0] N1,
    input  logic [CHANNELS-1:0] N2,
    input  logic [CHANNELS-1:0] N3,
    input  logic [CHANNELS-1:0] N6,
    input  logic [CHANNELS-1:0] N7,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHANNELS-1:0] N22,
    output logic [CHANNELS-1:0] N23,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    toggle_cnt
);

    // An illegal STAGES value falls back to the two-stage pipeline.
    localparam bit TWO_STAGE = !(stages_legal(STAGES) && (STAGES == 1));

    localparam int unsigned         SUM_W   = CNT_W + PC_W;
    localparam logic [CNT_W-1:0]    CNT_MAX = '1;

    logic [CHANNELS-1:0]   r22, r23;
    logic                  s2_up_valid, s2_up_ready;
    logic [2*CHANNELS-1:0] s2_data;

    if (TWO_STAGE) begin : g_two
        localparam int unsigned W1 = 4 * CHANNELS;

        logic [W1-1:0]       s1_in, s1_out;
        logic [CHANNELS-1:0] n10, a, n2r, n7r;

        // First stage captures the NAND node, the N1&N3 term and the pass-through inputs.
        always_comb begin
            s1_in = {~(N6 & N3), N1 & N3, N2, N7};
        end

        c17_pipe_stage #(.WIDTH(W1)) u_s1 (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (in_valid),
            .up_ready (in_ready),
            .up_data  (s1_in),
            .dn_valid (s2_up_valid),
            .dn_ready (s2_up_ready),
            .dn_data  (s1_out)
        );

        assign {n10, a, n2r, n7r} = s1_out;

        // Finish the c17 function from the registered internal nodes.
        always_comb begin
            r22 = a | (n2r & n10);
            r23 = n10 & (n2r | n7r);
        end
    end else begin : g_one
        assign s2_up_valid = in_valid;
        assign in_ready    = s2_up_ready;

        // Whole c17 function straight from the inputs, one channel at a time.
        always_comb begin
            r22 = '0;
            r23 = '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                {r22[i], r23[i]} = c17_eval(N1[i], N2[i], N3[i], N6[i], N7[i]);
            end
        end
    end

    c17_pipe_stage #(.WIDTH(2 * CHANNELS)) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (s2_up_valid),
        .up_ready (s2_up_ready),
        .up_data  ({r22, r23}),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (s2_data)
    );

    assign {N22, N23} = s2_data;

    logic [CHANNELS-1:0] p22_q, p23_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_hs;
    logic [PC_W-1:0]     inc;
    logic [SUM_W-1:0]    sum;

    // A channel counts once per transfer if either of its outputs changed; clear wins.
    always_comb begin
        out_hs = out_valid & out_ready;
        inc    = popcount(MAX_CH'((N22 ^ p22_q) | (N23 ^ p23_q)));
        sum    = SUM_W'(cnt_q) + SUM_W'(inc);
        cnt_d  = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_hs) begin
            cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        end
    end

    // Counter and last-transferred output history; history survives cnt_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            p22_q <= '0;
            p23_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (out_hs) begin
                p22_q <= N22;
                p23_q <= N23;
            end
        end
    end

    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_c17_pipe_array.sv
// Self-checking bench: directed and random vectors against a queue-based reference model.
module tb_c17_pipe_array;

    localparam int unsigned CH   = 4;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    typedef struct {
        logic [CH-1:0] n22;
        logic [CH-1:0] n23;
    } exp_t;

    logic          clk, rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [CH-1:0] N1, N2, N3, N6, N7, N22, N23;
    logic [CW-1:0] toggle_cnt;

    logic          in_valid1, in_ready1, out_valid1;
    logic [0:0]    a1, b1, c1, d1, e1, o22_1, o23_1;
    logic [15:0]   toggle_cnt1;

    int            checks   = 0;
    int            failures = 0;
    exp_t          exp_q[$];
    logic [CH-1:0] m_p22, m_p23;
    int            m_cnt;
    int            n_out;
    int            base;
    logic [CH-1:0][4:0] rv;

    c17_pipe_array #(.CHANNELS(CH), .STAGES(2), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .N1(N1), .N2(N2), .N3(N3), .N6(N6), .N7(N7),
        .out_valid(out_valid), .out_ready(out_ready), .N22(N22), .N23(N23),
        .cnt_clr(cnt_clr), .toggle_cnt(toggle_cnt)
    );

    c17_pipe_array #(.CHANNELS(1), .STAGES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .N1(a1), .N2(b1), .N3(c1), .N6(d1), .N7(e1),
        .out_valid(out_valid1), .out_ready(1'b1), .N22(o22_1), .N23(o23_1),
        .cnt_clr(1'b0), .toggle_cnt(toggle_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-channel c17 truth from the gate equations.
    function automatic exp_t ref_c17(input logic [CH-1:0] a, input logic [CH-1:0] b,
                                     input logic [CH-1:0] c, input logic [CH-1:0] d,
                                     input logic [CH-1:0] e);
        exp_t r;
        bit   nd;
        for (int i = 0; i < int'(CH); i++) begin
            nd        = !(d[i] && c[i]);
            r.n22[i]  = (a[i] && c[i]) || (b[i] && nd);
            r.n23[i]  = nd && (b[i] || e[i]);
        end
        return r;
    endfunction

    // Pattern per channel is {N1,N2,N3,N6,N7}.
    task automatic set_in(input logic [CH-1:0][4:0] p);
        for (int c = 0; c < int'(CH); c++) begin
            N1[c] = p[c][4];
            N2[c] = p[c][3];
            N3[c] = p[c][2];
            N6[c] = p[c][1];
            N7[c] = p[c][0];
        end
    endtask

    // One clock: called at a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        bit   ihs, ohs;
        exp_t e;
        int   tg;
        #1;
        ihs = (in_valid === 1'b1) && (in_ready === 1'b1);
        ohs = (out_valid === 1'b1) && (out_ready === 1'b1);
        tg  = 0;
        if (ohs) begin
            chk("out_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("N22", 32'(N22), 32'(e.n22));
                chk("N23", 32'(N23), 32'(e.n23));
                for (int c = 0; c < int'(CH); c++) begin
                    if (e.n22[c] != m_p22[c] || e.n23[c] != m_p23[c]) tg++;
                end
                m_p22 = e.n22;
                m_p23 = e.n23;
                n_out++;
            end
        end
        if (cnt_clr) m_cnt = 0;
        else if (ohs) m_cnt = (m_cnt + tg > CMAX) ? CMAX : m_cnt + tg;
        if (ihs) exp_q.push_back(ref_c17(N1, N2, N3, N6, N7));
        @(posedge clk);
        #1;
        chk("toggle_cnt", 32'(toggle_cnt), 32'(m_cnt));
        @(negedge clk);
    endtask

    task automatic send(input logic [CH-1:0][4:0] p, input bit clr);
        set_in(p);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        cnt_clr = clr;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        N1 = '0; N2 = '0; N3 = '0; N6 = '0; N7 = '0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; c1 = '0; d1 = '0; e1 = '0;
        m_p22 = '0; m_p23 = '0; m_cnt = 0; n_out = 0;

        // Reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_toggle_cnt", 32'(toggle_cnt), 0);
        chk("rst_N22", 32'(N22), 0);
        chk("rst_N23", 32'(N23), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector, two-cycle latency
        set_in({5'b01110, 5'b01000, 5'b00000, 5'b10110});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_lat1_out_valid", 32'(out_valid), 0);
        tick();
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_N22", 32'(N22), 32'(4'b0101));
        chk("t1_N23", 32'(N23), 32'(4'b0100));
        tick();
        chk("t1_toggle_cnt", 32'(toggle_cnt), 2);

        // Back-to-back random stream
        base = n_out;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                rv = (CH * 5)'($urandom);
                set_in(rv);
                in_valid = 1'b1;
                #1 chk("t2_in_ready", 32'(in_ready), 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        chk("t2_out_count", 32'(n_out - base), 8);
        chk("t2_drained", 32'(exp_q.size()), 0);

        // Backpressure: two vectors fill the pipe, then everything holds
        out_ready = 1'b0;
        base = n_out;
        for (int k = 0; k < 5; k++) begin
            rv = (CH * 5)'($urandom);
            set_in(rv);
            in_valid = 1'b1;
            #1;
            if (k >= 2) begin
                chk("t3_in_ready", 32'(in_ready), 0);
                chk("t3_out_valid", 32'(out_valid), 1);
                chk("t3_hold_N22", 32'(N22), 32'(exp_q[0].n22));
                chk("t3_hold_N23", 32'(N23), 32'(exp_q[0].n23));
            end
            tick();
        end
        chk("t3_inflight", 32'(exp_q.size()), 2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("t3_drain_count", 32'(n_out - base), 2);
        chk("t3_drained", 32'(exp_q.size()), 0);

        // Saturation and clear priority
        send({4{5'b00000}}, 1'b1);
        chk("t4_clr", 32'(toggle_cnt), 0);
        send({4{5'b01000}}, 1'b0);
        send({4{5'b00000}}, 1'b0);
        send({4{5'b01000}}, 1'b0);
        send({5'b00000, 5'b00000, 5'b01000, 5'b01000}, 1'b0);
        chk("t4_preload", 32'(toggle_cnt), 14);
        send({5'b01000, 5'b01000, 5'b01000, 5'b00000}, 1'b0);
        chk("t4_sat", 32'(toggle_cnt), 15);
        send({4{5'b00000}}, 1'b0);
        chk("t4_sat_hold", 32'(toggle_cnt), 15);
        send({4{5'b01000}}, 1'b1);
        chk("t4_clr_override", 32'(toggle_cnt), 0);

        // Asynchronous reset with two vectors in flight
        for (int k = 0; k < 2; k++) begin
            rv = (CH * 5)'($urandom);
            set_in(rv);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_toggle_cnt", 32'(toggle_cnt), 0);
        chk("t5_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        m_cnt = 0; m_p22 = '0; m_p23 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t5_idle_out_valid", 32'(out_valid), 0);
            tick();
        end

        // Single-stage, single-channel instance
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b0; d1 = 1'b0; e1 = 1'b0;
        in_valid1 = 1'b1;
        #1;
        chk("t6_pre_out_valid", 32'(out_valid1), 0);
        chk("t6_in_ready", 32'(in_ready1), 1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        chk("t6_out_valid", 32'(out_valid1), 1);
        chk("t6_N22", 32'(o22_1), 1);
        chk("t6_N23", 32'(o23_1), 1);
        @(posedge clk);
        #1;
        chk("t6_after_out_valid", 32'(out_valid1), 0);
        chk("t6_toggle_cnt", 32'(toggle_cnt1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
